// File: rtl/chorus_pkg.sv
`default_nettype none
// ============================================================
// chorus_pkg : shared widths and FSM encoding for the chorus delay line
// Revision   : 1.0
// ============================================================
package chorus_pkg;

  localparam int FRAC_W = 6;
  localparam int LFO_W  = 16;
  localparam int OFF_W  = 18;

  typedef logic [2:0] state_t;

  localparam state_t ST_CLEAR  = 3'd0;
  localparam state_t ST_IDLE   = 3'd1;
  localparam state_t ST_WRITE  = 3'd2;
  localparam state_t ST_RD_A   = 3'd3;
  localparam state_t ST_RD_B   = 3'd4;
  localparam state_t ST_CAP_B  = 3'd5;
  localparam state_t ST_INTERP = 3'd6;

endpackage
`default_nettype wire

// File: rtl/delay_ram.sv
`default_nettype none
// ============================================================
// delay_ram : single-port RAM, synchronous read-first, no storage reset
// Revision  : 1.0
// ============================================================
module delay_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [0:DEPTH-1];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/chorus_delay_line.sv
`default_nettype none
// ============================================================
// chorus_delay_line : LFO-modulated circular delay with linear interpolation
// Revision          : 1.0
// ============================================================
module chorus_delay_line
  import chorus_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 10,
  parameter int BASE_DELAY = 512,
  parameter int MOD_SHIFT  = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [DATA_W-1:0] sample_i,
  input  logic              sampleValid_i,
  input  logic [LFO_W-1:0]  lfo_i,
  input  logic              lfoValid_i,
  output logic [DATA_W-1:0] sample_o,
  output logic              sampleValid_o,
  output logic              ready_o,
  output logic              overrun_o
);

  localparam int PROD_W = DATA_W + FRAC_W + 2;
  localparam logic [OFF_W-1:0] BASE_Q6 = OFF_W'(BASE_DELAY << FRAC_W);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [DATA_W-1:0] sample_in_q, sample_in_d;
  logic [LFO_W-1:0]  lfo_reg_q, lfo_reg_d;
  logic [LFO_W-1:0]  lfo_snap_q, lfo_snap_d;
  logic [DATA_W-1:0] xa_q, xa_d;
  logic [DATA_W-1:0] xb_q, xb_d;
  logic [DATA_W-1:0] sample_out_q, sample_out_d;
  logic              valid_q, valid_d;
  logic              ready_q, ready_d;
  logic              overrun_q, overrun_d;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic signed [LFO_W-1:0]  lfo_shift;
  logic        [OFF_W-1:0]  off_q6;
  logic        [ADDR_W-1:0] delay_int;
  logic        [FRAC_W-1:0] frac;
  logic        [ADDR_W-1:0] addr_a;
  logic        [ADDR_W-1:0] addr_b;

  logic signed [PROD_W-1:0] xa_ext, xb_ext, diff, frac_ext, prod, interp_sum;
  logic                     unused_bits;

  // Q.6 read offset: integer part selects the tap, low bits weight the neighbour
  always_comb begin
    lfo_shift = $signed(lfo_snap_q) >>> MOD_SHIFT;
    off_q6    = BASE_Q6 + {{(OFF_W-LFO_W){lfo_shift[LFO_W-1]}}, lfo_shift};
    delay_int = off_q6[FRAC_W +: ADDR_W];
    frac      = off_q6[FRAC_W-1:0];
    addr_a    = wr_ptr_q - delay_int;
    addr_b    = addr_a - ADDR_W'(1);
  end

  // Products are kept wide enough that the floor shift never overflows
  always_comb begin
    xa_ext     = {{(PROD_W-DATA_W){xa_q[DATA_W-1]}}, xa_q};
    xb_ext     = {{(PROD_W-DATA_W){xb_q[DATA_W-1]}}, xb_q};
    diff       = xb_ext - xa_ext;
    frac_ext   = {{(PROD_W-FRAC_W){1'b0}}, frac};
    prod       = diff * frac_ext;
    interp_sum = xa_ext + (prod >>> FRAC_W);
  end

  assign unused_bits = ^{off_q6[OFF_W-1:FRAC_W+ADDR_W], interp_sum[PROD_W-1:DATA_W]};

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    sample_in_d  = sample_in_q;
    lfo_reg_d    = lfo_reg_q;
    lfo_snap_d   = lfo_snap_q;
    xa_d         = xa_q;
    xb_d         = xb_q;
    sample_out_d = sample_out_q;
    valid_d      = 1'b0;
    ready_d      = ready_q;
    overrun_d    = overrun_q;
    ram_we       = 1'b0;
    ram_addr     = wr_ptr_q;
    ram_wdata    = sample_in_q;

    if (lfoValid_i) begin
      lfo_reg_d = lfo_i;
    end

    if (sampleValid_i && (state_q != ST_IDLE) && (state_q != ST_CLEAR)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_addr  = clr_cnt_q;
        ram_wdata = '0;
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (&clr_cnt_q) begin
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (sampleValid_i) begin
          // Snapshot the registered LFO so a same-cycle update waits a sample
          sample_in_d = sample_i;
          lfo_snap_d  = lfo_reg_q;
          state_d     = ST_WRITE;
        end
      end
      ST_WRITE: begin
        ram_we  = 1'b1;
        state_d = ST_RD_A;
      end
      ST_RD_A: begin
        ram_addr = addr_a;
        state_d  = ST_RD_B;
      end
      ST_RD_B: begin
        ram_addr = addr_b;
        xa_d     = ram_rdata;
        state_d  = ST_CAP_B;
      end
      ST_CAP_B: begin
        xb_d    = ram_rdata;
        state_d = ST_INTERP;
      end
      ST_INTERP: begin
        sample_out_d = interp_sum[DATA_W-1:0];
        valid_d      = 1'b1;
        wr_ptr_d     = wr_ptr_q + ADDR_W'(1);
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q      <= ST_CLEAR;
      clr_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      sample_in_q  <= '0;
      lfo_reg_q    <= '0;
      lfo_snap_q   <= '0;
      xa_q         <= '0;
      xb_q         <= '0;
      sample_out_q <= '0;
      valid_q      <= 1'b0;
      ready_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      sample_in_q  <= sample_in_d;
      lfo_reg_q    <= lfo_reg_d;
      lfo_snap_q   <= lfo_snap_d;
      xa_q         <= xa_d;
      xb_q         <= xb_d;
      sample_out_q <= sample_out_d;
      valid_q      <= valid_d;
      ready_q      <= ready_d;
      overrun_q    <= overrun_d;
    end
  end

  delay_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  assign sample_o      = sample_out_q;
  assign sampleValid_o = valid_q;
  assign ready_o       = ready_q;
  assign overrun_o     = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_chorus_delay_line.sv
`default_nettype none
// ============================================================
// tb_chorus_delay_line : directed vectors for the chorus delay line
// Revision             : 1.0
// ============================================================
module tb_chorus_delay_line;

  localparam int DEPTH = 1024;
  localparam int NV    = 10;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [15:0] sample_i = '0;
  logic        sampleValid_i = 1'b0;
  logic [15:0] lfo_i = '0;
  logic        lfoValid_i = 1'b0;
  logic [15:0] sample_o;
  logic        sampleValid_o;
  logic        ready_o;
  logic        overrun_o;

  always #5 clk = ~clk;

  chorus_delay_line #(
    .DATA_W     (16),
    .ADDR_W     (10),
    .BASE_DELAY (512),
    .MOD_SHIFT  (4)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .sample_i      (sample_i),
    .sampleValid_i (sampleValid_i),
    .lfo_i         (lfo_i),
    .lfoValid_i    (lfoValid_i),
    .sample_o      (sample_o),
    .sampleValid_o (sampleValid_o),
    .ready_o       (ready_o),
    .overrun_o     (overrun_o)
  );

  typedef struct {
    logic [15:0] lfo;
    logic [15:0] xa;
    logic [15:0] xb;
    logic [15:0] exp;
  } vec_t;

  vec_t        tab [NV];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          agg_bad;
  int          pulses;
  logic [15:0] lv, sv, got, exp_v, seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lfo(input logic [15:0] v);
    lfo_i      = v;
    lfoValid_i = 1'b1;
    tick();
    lfoValid_i = 1'b0;
  endtask

  // One sample strobe; returns the output and checks latency and pulse width
  task automatic send(input logic [15:0] s, input bit co_lfo, input logic [15:0] co_val,
                      output logic [15:0] out);
    int pos;
    bit seen_valid;
    pos        = 0;
    seen_valid = 1'b0;
    out        = 16'hDEAD;
    sample_i      = s;
    sampleValid_i = 1'b1;
    if (co_lfo) begin
      lfo_i      = co_val;
      lfoValid_i = 1'b1;
    end
    tick();
    sampleValid_i = 1'b0;
    lfoValid_i    = 1'b0;
    while (!seen_valid && pos <= 10) begin
      if (sampleValid_o === 1'b1) begin
        seen_valid = 1'b1;
        out        = sample_o;
      end else begin
        tick();
        pos++;
      end
    end
    check("valid_latency", seen_valid ? pos : 99, 5);
    tick();
    check("valid_pulse_width", sampleValid_o, 0);
  endtask

  task automatic wait_clear(input string tag);
    int bad;
    bad = 0;
    for (int i = 1; i < DEPTH; i++) begin
      tick();
      sampleValid_i = (i == 100);
      if (ready_o !== 1'b0 || sample_o !== 16'h0 || sampleValid_o !== 1'b0 || overrun_o !== 1'b0)
        bad++;
    end
    sampleValid_i = 1'b0;
    check({tag, "_clear_quiet_cycles"}, bad, 0);
    tick();
    check({tag, "_ready_after_clear"}, ready_o, 1);
  endtask

  task automatic apply_reset(input string tag);
    reset_i       = 1'b0;
    sampleValid_i = 1'b0;
    lfoValid_i    = 1'b0;
    #1;
    check({tag, "_rst_sample_o"}, sample_o, 0);
    check({tag, "_rst_valid"}, sampleValid_o, 0);
    check({tag, "_rst_ready"}, ready_o, 0);
    check({tag, "_rst_overrun"}, overrun_o, 0);
    tick();
    tick();
    reset_i = 1'b1;
    wait_clear(tag);
  endtask

  function automatic logic [15:0] ramp(input int k);
    return 16'(k * 7 + 3);
  endfunction

  initial begin
    // {lfo, xA, xB, expected}; lfo in [0,1023] keeps d=512, frac=lfo>>4
    tab[0] = '{16'h0000, 16'h1234, 16'hFFFF, 16'h1234};
    tab[1] = '{16'h0200, 16'h4000, 16'h0000, 16'h2000};
    tab[2] = '{16'h0200, 16'h0000, 16'h4000, 16'h2000};
    tab[3] = '{16'h0010, 16'h0000, 16'h0064, 16'h0001};
    tab[4] = '{16'h0010, 16'h0000, 16'hFF9C, 16'hFFFE};
    tab[5] = '{16'h03F0, 16'h8000, 16'h7FFF, 16'h7BFF};
    tab[6] = '{16'h03F0, 16'h7FFF, 16'h8000, 16'h83FF};
    tab[7] = '{16'h0100, 16'h03E8, 16'h07D0, 16'h04E2};
    tab[8] = '{16'h0190, 16'hFFF9, 16'hFFF9, 16'hFFF9};
    tab[9] = '{16'h0320, 16'h000A, 16'hFFF6, 16'hFFFA};

    #2;
    apply_reset("init");

    // Table phase: xB then xA per vector, each read back 512 samples later
    agg_bad = 0;
    for (int k = 0; k < 512 + 2 * NV; k++) begin
      lv = (k >= 512) ? tab[(k - 512) / 2].lfo : 16'h0000;
      if (k < 2 * NV) sv = (k % 2 == 0) ? tab[k / 2].xb : tab[k / 2].xa;
      else            sv = 16'h0000;
      set_lfo(lv);
      send(sv, 1'b0, 16'h0, got);
      if (k < 512) begin
        if (got !== 16'h0000) agg_bad++;
      end else if ((k - 512) % 2 == 1) begin
        check($sformatf("interp_vec%0d", (k - 512) / 2), got, tab[(k - 512) / 2].exp);
      end
    end
    check("fill_outputs_zero", agg_bad, 0);

    // Negative extreme, coincident LFO strobe, then integer delay of 512
    apply_reset("neg");
    set_lfo(16'h8000);
    agg_bad = 0;
    for (int k = 0; k < 520; k++) begin
      sv    = (k == 0) ? 16'h4000 : 16'h0000;
      exp_v = (k == 480 || k == 512) ? 16'h4000 : 16'h0000;
      send(sv, (k == 480), 16'h0000, got);
      if (k == 479 || k == 480 || k == 481 || k == 511 || k == 512 || k == 513)
        check($sformatf("impulse_out%0d", k), got, exp_v);
      else if (got !== exp_v)
        agg_bad++;
    end
    check("impulse_other_outputs", agg_bad, 0);

    // Ramp across the write-pointer wrap
    apply_reset("ramp");
    set_lfo(16'h0000);
    agg_bad = 0;
    for (int k = 0; k < 1500; k++) begin
      exp_v = (k >= 512) ? ramp(k - 512) : 16'h0000;
      send(ramp(k), 1'b0, 16'h0, got);
      if (k == 512 || k == 1023 || k == 1024 || k == 1025 || k == 1499)
        check($sformatf("ramp_out%0d", k), got, exp_v);
      else if (got !== exp_v)
        agg_bad++;
    end
    check("ramp_other_outputs", agg_bad, 0);

    // Two strobes three cycles apart: one output, sticky overrun
    check("overrun_before", overrun_o, 0);
    sample_i      = 16'h5555;
    sampleValid_i = 1'b1;
    tick();
    sampleValid_i = 1'b0;
    tick();
    tick();
    sample_i      = 16'hAAAA;
    sampleValid_i = 1'b1;
    tick();
    sampleValid_i = 1'b0;
    pulses = 0;
    seen   = 16'h0;
    for (int i = 0; i < 12; i++) begin
      if (sampleValid_o === 1'b1) begin
        pulses++;
        seen = sample_o;
      end
      tick();
    end
    check("overrun_pulse_count", pulses, 1);
    check("overrun_sample_value", seen, ramp(988));
    check("overrun_set", overrun_o, 1);
    send(16'h0000, 1'b0, 16'h0, got);
    check("after_drop_value", got, ramp(989));
    check("overrun_sticky", overrun_o, 1);

    // Reset while the FSM sits in RD_B
    sample_i      = 16'h1111;
    sampleValid_i = 1'b1;
    tick();
    sampleValid_i = 1'b0;
    tick();
    tick();
    apply_reset("midrst");
    send(16'h7777, 1'b0, 16'h0, got);
    check("post_midrst_output", got, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/chorus_delay_line.md
# chorus_delay_line

Modulated audio delay line that consumes the LFO's signed waveform and its new-value strobe. It writes each incoming 44.1 kHz audio sample into a circular buffer and reads back a linearly interpolated sample at a delay of `BASE_DELAY` plus an LFO-driven fractional offset. It sits downstream of the sample FIFO and LFO generator and produces the wet chorus signal for the output mixer.

## Interface

Parameters:
- `DATA_W`, default 16: audio sample width, signed two's complement.
- `ADDR_W`, default 10: buffer address width; `DEPTH = 2**ADDR_W` = 1024.
- `BASE_DELAY`, default 512: nominal delay in samples.
  - Legal range: 33 ≤ `BASE_DELAY` ≤ `DEPTH`−34.
- `MOD_SHIFT`, default 4: arithmetic right shift applied to `lfo_i`.

Ports (one clock; reset is asynchronous and active-low):
- `clk_i` in 1: system clock, 6 MHz.
- `reset_i` in 1: asynchronous, active-low reset.
- `sample_i` in `DATA_W`: signed dry audio sample.
- `sampleValid_i` in 1: one-cycle strobe marking a new sample. Nominally every 136 cycles.
- `lfo_i` in 16: signed LFO waveform value.
- `lfoValid_i` in 1: one-cycle strobe; `lfo_i` is valid in that cycle.
- `sample_o` out `DATA_W`: signed delayed/interpolated sample, held between updates.
- `sampleValid_o` out 1: one-cycle strobe; `sample_o` is new.
- `ready_o` out 1: high once the buffer clear has completed.
- `overrun_o` out 1: sticky; set when a sample strobe is dropped while busy.

## Operation

- **Reset (reset_i=0):**
  - All outputs go to 0 and `lfoReg` goes to 0.
  - `wrPtr` goes to 0 and the FSM goes to CLEAR.
- **CLEAR:** writes 0 to addresses 0..`DEPTH`−1, one per cycle. Then `ready_o`←1 and the FSM goes to IDLE. Strobes arriving in CLEAR are ignored and do not set `overrun_o`.
- **LFO capture:** `lfoReg` ← `lfo_i` on any cycle with `lfoValid_i`=1, in any state.
- **IDLE:** on `sampleValid_i`=1, latch `sample_i` and snapshot `lfoReg`. The pre-update value is used, so a same-cycle `lfoValid_i` applies to the next sample.
- **Delay arithmetic:**
  - Q.6 fixed point: `off` = `BASE_DELAY`·64 + (`lfoSnap` >>> `MOD_SHIFT`). Signed, 18 bits.
  - `d` = `off`[17:6] (integer delay); `frac` = `off`[5:0].
  - Range with defaults: `d` ∈ [480, 543].
- **Addresses:** `A` = `wrPtr` − `d`, `B` = `A` − 1, both modulo `DEPTH`. `wrPtr` here is the address the current sample is written to.
- **Interpolation:**
  - `sample_o` = `xA` + ((`xB` − `xA`)·`frac`) >>> 6.
  - The difference is 17-bit signed, the product is 24-bit signed, and the shift is arithmetic (floor).
  - The result always lies between `xA` and `xB`, so no saturation is needed; truncate to `DATA_W`.
- **FSM sequence:** IDLE → WRITE → RD_A → RD_B → CAP_B → INTERP → IDLE.
  - WRITE: RAM write at `wrPtr`.
  - RD_A: read address `A`.
  - RD_B: read address `B`; capture `xA`.
  - CAP_B: capture `xB`.
  - INTERP: compute, register `sample_o`, pulse `sampleValid_o`, and `wrPtr`←`wrPtr`+1 (wraps 1023→0).
- **Busy strobe:** `sampleValid_i`=1 in any state other than IDLE/CLEAR drops the sample and sets `overrun_o`=1. `overrun_o` clears only on reset.

## Timing

- The RAM has a 1-cycle synchronous read and a single port: one access per cycle.
- Latency:
  - `sampleValid_i` sampled high at edge N → `sampleValid_o` high for exactly the cycle after edge N+5.
  - `sample_o` updates at the same edge and holds until the next update.
- Throughput: one sample per 6 cycles maximum. This is far above the 136-cycle nominal rate.
- `ready_o` rises `DEPTH` cycles after reset deassertion.
- Reset asserted mid-sequence: the in-flight sample is discarded, with no `sampleValid_o` pulse. The FSM re-enters CLEAR on release.

## Structure

- Package `chorus_pkg` holds:
  - The state enum (CLEAR, IDLE, WRITE, RD_A, RD_B, CAP_B, INTERP).
  - `FRAC_W`=6.
  - `LFO_W`=16.
- One sub-module, `delay_ram`: single-port, synchronous-read, `DEPTH`×`DATA_W`. Inferable as iCE40 EBR, with no reset on the storage array.

## Test plan

1. **Reset and clear:** release reset → `ready_o`=0 for 1024 cycles, then 1. Throughout, `sample_o`=0, `sampleValid_o`=0 and `overrun_o`=0.
2. **Integer delay:** `lfo_i`=0 (off=32768, frac=0); impulse 16'h4000 at sample n, zeros elsewhere → output 16'h4000 exactly at output n+512, 0 otherwise. `sampleValid_o` comes 6 edges after each input strobe.
3. **Half-sample delay:** `lfo_i`=+512 (frac=32) → outputs n+512 and n+513 both equal 16'h2000.
4. **Negative extreme:** `lfo_i`=−32768 → impulse appears at output n+480 with value 16'h4000. `lfoValid_i` coincident with `sampleValid_i` must take effect one sample later.
5. **Wrap-around:** 1500-sample ramp with `lfo_i`=0 → output equals the input delayed by 512 across the `wrPtr` 1023→0 wrap.
6. **Overrun and mid-operation reset:**
   - Two input strobes 3 cycles apart → one `sampleValid_o`, and `overrun_o`=1 sticky.
   - Reset asserted in RD_B → outputs 0 immediately, no pulse, and `ready_o` re-clears.
